// File: rtl/mux_sel_sequencer.sv
// Serializes an 8-bit word by stepping the select of an external 8-to-1 mux
// and streaming the returned mux output with valid/ready framing.
module mux_sel_sequencer #(
  parameter int LSB_FIRST = 1,
  parameter int IDLE_GAP  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] w,
  output logic [2:0] s,
  input  logic       f_in,
  output logic       ser_data,
  output logic       ser_valid,
  input  logic       ser_ready,
  output logic       ser_first,
  output logic       ser_last,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } state_t;

  localparam logic [2:0] START_IDX = (LSB_FIRST != 0) ? 3'd0 : 3'd7;
  localparam logic [2:0] END_IDX   = (LSB_FIRST != 0) ? 3'd7 : 3'd0;
  localparam logic [3:0] GAP_LAST  = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;
  localparam logic       NO_GAP    = (IDLE_GAP == 0);

  state_t     state_reg;
  logic [7:0] w_reg;
  logic [2:0] idx_reg;
  logic [3:0] gap_cnt_reg;
  logic       frame_done_reg;

  logic       in_shift;
  logic       xfer;
  logic       last_xfer;
  logic       load;
  logic [2:0] idx_next;

  // Outputs are masked while rst is held so nothing looks active before the
  // first reset edge has cleared the state.
  assign in_shift  = (state_reg == SHIFT) && !rst;
  assign ser_valid = in_shift;
  assign ser_first = in_shift && (idx_reg == START_IDX);
  assign ser_last  = in_shift && (idx_reg == END_IDX);
  assign busy      = !rst && (state_reg != IDLE);

  assign xfer      = ser_valid && ser_ready;
  assign last_xfer = xfer && ser_last;

  // Accepting on the final bit lets frames run back to back without a bubble.
  assign din_ready = !rst && ((state_reg == IDLE) || (last_xfer && NO_GAP));
  assign load      = din_valid && din_ready;

  assign idx_next   = (LSB_FIRST != 0) ? idx_reg + 3'd1 : idx_reg - 3'd1;

  assign ser_data   = f_in;
  assign w          = w_reg;
  assign s          = idx_reg;
  assign frame_done = frame_done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      w_reg          <= 8'h00;
      idx_reg        <= START_IDX;
      gap_cnt_reg    <= 4'd0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= last_xfer;

      if (load) begin
        w_reg   <= din;
        idx_reg <= START_IDX;
      end

      case (state_reg)
        IDLE: begin
          if (load) state_reg <= SHIFT;
        end
        SHIFT: begin
          if (xfer) begin
            // The index parks on the end value after the last bit; only a
            // load moves it again, so s keeps its last value while idle.
            if (ser_last) begin
              if (!NO_GAP) begin
                state_reg   <= GAP;
                gap_cnt_reg <= 4'd0;
              end else if (load) begin
                state_reg <= SHIFT;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              idx_reg <= idx_next;
            end
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg   <= IDLE;
            gap_cnt_reg <= 4'd0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: one LSB-first no-gap instance and one MSB-first
// instance with a 3-cycle gap, each closed through a behavioural 8-to-1 mux.
module tb_mux_sel_sequencer;

  typedef struct {
    logic       d;
    logic [2:0] s;
    logic       f;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic [7:0] din_a, w_a;
  logic [2:0] s_a;
  logic din_valid_a, din_ready_a, f_in_a, ser_data_a, ser_valid_a, ser_ready_a;
  logic ser_first_a, ser_last_a, busy_a, frame_done_a;

  logic [7:0] din_b, w_b;
  logic [2:0] s_b;
  logic din_valid_b, din_ready_b, f_in_b, ser_data_b, ser_valid_b, ser_ready_b;
  logic ser_first_b, ser_last_b, busy_b, frame_done_b;

  exp_t qa[$];
  exp_t qb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   vcnt_a = 0;
  int   fd_last_a = 0;
  int   fd_gap_a = 0;
  int   v0;
  logic fd_exp_a = 1'b0;
  logic fd_exp_b = 1'b0;

  always #5 clk = ~clk;

  assign f_in_a = w_a[s_a];
  assign f_in_b = w_b[s_b];

  mux_sel_sequencer #(.LSB_FIRST(1), .IDLE_GAP(0)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(din_valid_a), .din_ready(din_ready_a),
    .w(w_a), .s(s_a), .f_in(f_in_a), .ser_data(ser_data_a), .ser_valid(ser_valid_a),
    .ser_ready(ser_ready_a), .ser_first(ser_first_a), .ser_last(ser_last_a),
    .busy(busy_a), .frame_done(frame_done_a)
  );

  mux_sel_sequencer #(.LSB_FIRST(0), .IDLE_GAP(3)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
    .w(w_b), .s(s_b), .f_in(f_in_b), .ser_data(ser_data_b), .ser_valid(ser_valid_b),
    .ser_ready(ser_ready_b), .ser_first(ser_first_b), .ser_last(ser_last_b),
    .busy(busy_b), .frame_done(frame_done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bit stream of one frame, derived from the word and bit order.
  task automatic push_word(input bit to_b, input logic [7:0] word, input bit lsb);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.s = lsb ? 3'(k) : 3'(7 - k);
      e.d = word[e.s];
      e.f = (k == 0);
      e.l = (k == 7);
      if (to_b) qb.push_back(e);
      else qa.push_back(e);
    end
  endtask

  // Inputs are set at a falling edge; this checks the cycle's handshake and
  // then advances through the rising edge to the next falling edge.
  task automatic tick();
    exp_t e;
    #1;
    chk("frame_done_a", 32'(frame_done_a), 32'(fd_exp_a));
    if (frame_done_a === 1'b1) begin
      fd_gap_a  = cyc - fd_last_a;
      fd_last_a = cyc;
    end
    if (ser_valid_a === 1'b1) vcnt_a++;
    fd_exp_a = 1'b0;
    if (ser_valid_a === 1'b1 && ser_ready_a) begin
      if (qa.size() == 0) chk("xfer_a_unexpected", 32'(ser_valid_a), 32'd0);
      else begin
        e = qa.pop_front();
        chk("ser_data_a", 32'(ser_data_a), 32'(e.d));
        chk("s_a", 32'(s_a), 32'(e.s));
        chk("ser_first_a", 32'(ser_first_a), 32'(e.f));
        chk("ser_last_a", 32'(ser_last_a), 32'(e.l));
        fd_exp_a = e.l && !rst;
      end
    end
    chk("frame_done_b", 32'(frame_done_b), 32'(fd_exp_b));
    fd_exp_b = 1'b0;
    if (ser_valid_b === 1'b1 && ser_ready_b) begin
      if (qb.size() == 0) chk("xfer_b_unexpected", 32'(ser_valid_b), 32'd0);
      else begin
        e = qb.pop_front();
        chk("ser_data_b", 32'(ser_data_b), 32'(e.d));
        chk("s_b", 32'(s_b), 32'(e.s));
        chk("ser_first_b", 32'(ser_first_b), 32'(e.f));
        chk("ser_last_b", 32'(ser_last_b), 32'(e.l));
        fd_exp_b = e.l && !rst;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    din_a = 8'hFF; din_valid_a = 1'b1; ser_ready_a = 1'b1;
    din_b = 8'h00; din_valid_b = 1'b0; ser_ready_b = 1'b1;
    @(negedge clk);

    // Reset state; din_valid high during reset must not load
    chk("rst_ser_valid_a", 32'(ser_valid_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_first_last_a", 32'({ser_first_a, ser_last_a}), 32'd0);
    chk("rst_w_a", 32'(w_a), 32'h00);
    chk("rst_s_a", 32'(s_a), 32'd0);
    chk("rst_s_b", 32'(s_b), 32'd7);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    tick();
    rst = 1'b0; din_valid_a = 1'b0;
    #1;
    chk("post_rst_din_ready_a", 32'(din_ready_a), 32'd1);
    chk("post_rst_din_ready_b", 32'(din_ready_b), 32'd1);
    chk("post_rst_w_a", 32'(w_a), 32'h00);
    tick();

    // Basic LSB-first frame of A5
    din_a = 8'hA5; din_valid_a = 1'b1; push_word(1'b0, 8'hA5, 1'b1);
    tick();
    din_valid_a = 1'b0;
    chk("basic_w_a", 32'(w_a), 32'hA5);
    chk("basic_first_a", 32'(ser_first_a), 32'd1);
    repeat (8) tick();
    chk("basic_done_a", 32'(frame_done_a), 32'd1);
    chk("basic_idle_a", 32'(ser_valid_a), 32'd0);
    tick();
    chk("basic_done_once_a", 32'(frame_done_a), 32'd0);
    chk("basic_busy_a", 32'(busy_a), 32'd0);

    // MSB-first frame of 81 followed by a 3-cycle gap
    din_b = 8'h81; din_valid_b = 1'b1; push_word(1'b1, 8'h81, 1'b0);
    tick();
    din_valid_b = 1'b0;
    chk("order_s_b", 32'(s_b), 32'd7);
    repeat (8) tick();
    din_b = 8'hFF; din_valid_b = 1'b1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("gap%0d_din_ready_b", g), 32'(din_ready_b), 32'd0);
      chk($sformatf("gap%0d_busy_b", g), 32'(busy_b), 32'd1);
      tick();
    end
    din_valid_b = 1'b0;
    chk("gap_end_din_ready_b", 32'(din_ready_b), 32'd1);
    chk("gap_end_busy_b", 32'(busy_b), 32'd0);
    chk("gap_hold_w_b", 32'(w_b), 32'h81);
    tick();

    // Back-pressure: 3 stalled cycles at s=4
    din_a = 8'h6B; din_valid_a = 1'b1; push_word(1'b0, 8'h6B, 1'b1);
    v0 = vcnt_a;
    tick();
    din_valid_a = 1'b0;
    repeat (4) tick();
    ser_ready_a = 1'b0;
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("stall_s_a", 32'(s_a), 32'd4);
      chk("stall_w_a", 32'(w_a), 32'h6B);
      chk("stall_valid_a", 32'(ser_valid_a), 32'd1);
    end
    ser_ready_a = 1'b1;
    repeat (4) tick();
    chk("stall_frame_len_a", 32'(vcnt_a - v0), 32'd11);
    tick();

    // Back-to-back 0F then F0 with din_valid held
    din_a = 8'h0F; din_valid_a = 1'b1; push_word(1'b0, 8'h0F, 1'b1);
    tick();
    din_a = 8'hF0; push_word(1'b0, 8'hF0, 1'b1);
    v0 = vcnt_a;
    repeat (7) tick();
    #1;
    chk("b2b_din_ready_last_a", 32'(din_ready_a), 32'd1);
    tick();
    din_valid_a = 1'b0;
    repeat (8) tick();
    chk("b2b_valid_bits_a", 32'(vcnt_a - v0), 32'd16);
    tick();
    chk("b2b_done_spacing_a", 32'(fd_gap_a), 32'd8);

    // Reset mid-frame at s=5, with a competing din_valid
    din_a = 8'h3C; din_valid_a = 1'b1; push_word(1'b0, 8'h3C, 1'b1);
    tick();
    din_valid_a = 1'b0;
    repeat (5) tick();
    chk("midrst_s_before_a", 32'(s_a), 32'd5);
    rst = 1'b1; din_a = 8'hFF; din_valid_a = 1'b1;
    qa.delete();
    tick();
    rst = 1'b0; din_valid_a = 1'b0;
    chk("midrst_valid_a", 32'(ser_valid_a), 32'd0);
    chk("midrst_w_a", 32'(w_a), 32'h00);
    chk("midrst_busy_a", 32'(busy_a), 32'd0);
    chk("midrst_s_a", 32'(s_a), 32'd0);
    tick();
    din_a = 8'h5A; din_valid_a = 1'b1; push_word(1'b0, 8'h5A, 1'b1);
    tick();
    din_valid_a = 1'b0;
    chk("midrst_reload_s_a", 32'(s_a), 32'd0);
    repeat (9) tick();

    chk("queue_a_drained", 32'(qa.size()), 32'd0);
    chk("queue_b_drained", 32'(qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_sel_sequencer.md
MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

Interface
REQ-001 The block SHALL provide parameter LSB_FIRST, default 1, which selects bit order: 1 = w[0] first, 0 = w[7] first.
REQ-002 The block SHALL provide parameter IDLE_GAP, default 0, the number of idle cycles inserted after each frame (range 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port din, input, 8 bits: parallel word to serialize.
REQ-006 The block SHALL have port din_valid, input, 1 bit: din is offered.
REQ-007 The block SHALL have port din_ready, output, 1 bit: the block can accept din this cycle.
REQ-008 The block SHALL have port w, output, 8 bits: the held word, driven to the 8-to-1 mux data inputs.
REQ-009 The block SHALL have port s, output, 3 bits: the mux select.
REQ-010 The block SHALL have port f_in, input, 1 bit: the mux output, returned to the block.
REQ-011 The block SHALL have port ser_data, output, 1 bit: the serial bit, a direct combinational copy of f_in.
REQ-012 The block SHALL have port ser_valid, output, 1 bit: ser_data is valid.
REQ-013 The block SHALL have port ser_ready, input, 1 bit: downstream accepts ser_data.
REQ-014 The block SHALL have ports ser_first and ser_last, outputs, 1 bit each: they mark the first and last bit of the frame.
REQ-015 The block SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-016 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse at frame completion.

Function
REQ-017 FSM states SHALL be IDLE, SHIFT and GAP, with 2-bit encoding.
REQ-018 Word load: a load SHALL occur on din_valid && din_ready; w <= din; the bit index is set to the start value (0 if LSB_FIRST = 1, else 7); next state is SHIFT.
REQ-019 din_ready SHALL be 1 in IDLE, and also 1 in SHIFT when the last bit transfers in the same cycle (ser_ready && ser_last) and IDLE_GAP = 0, for back-to-back frames; otherwise 0.
REQ-020 Input handling: din_valid SHALL be ignored while din_ready = 0, and w SHALL hold its value.
REQ-021 In SHIFT: ser_valid = 1 and s = bit index; in IDLE and GAP: ser_valid = 0 and s holds its last value.
REQ-022 Transfer: a transfer SHALL occur on ser_valid && ser_ready; the index increments (LSB_FIRST = 1) or decrements (LSB_FIRST = 0) by 1 per transfer.
REQ-023 Stall: with ser_ready = 0 in SHIFT, s, w and the index SHALL hold and ser_valid SHALL stay 1.
REQ-024 Frame markers: ser_first SHALL be 1 when the index equals the start value and ser_last SHALL be 1 when the index equals the end value (7, or 0); both SHALL be 0 outside SHIFT.
REQ-025 Last-bit transfer: the next state SHALL be GAP if IDLE_GAP > 0; if IDLE_GAP = 0 it SHALL be SHIFT when a load occurs in the same cycle, else IDLE.
REQ-026 frame_done SHALL be registered and assert for exactly 1 cycle, in the cycle after the last-bit transfer.
REQ-027 GAP: a 4-bit counter SHALL count IDLE_GAP cycles, then the state returns to IDLE; din_ready = 0 throughout.
REQ-028 Frame length SHALL be exactly 8 transfers, with no index wrap-around inside a frame; the index SHALL be reloaded only by a load.
REQ-029 Minimum frame duration SHALL be 8 cycles of ser_valid with ser_ready held at 1; throughput SHALL be one word per 8 cycles when IDLE_GAP = 0.
REQ-030 ser_data SHALL have zero latency from f_in; the block SHALL assume the mux is purely combinational.

Reset
REQ-031 When rst = 1 at a clock edge, the block SHALL set state = IDLE, w = 8'h00, s = the start value, GAP counter = 0, and frame_done = 0.
REQ-032 While in reset, outputs SHALL be ser_valid = 0, ser_first = 0, ser_last = 0, busy = 0, and din_ready = 1 in the cycle after reset releases.
REQ-033 Reset mid-frame SHALL abort the frame immediately, discard the remaining bits, and generate no frame_done pulse.
REQ-034 When rst and din_valid are high in the same cycle, reset SHALL win and no load SHALL occur.

Verification
REQ-035 Basic: LSB_FIRST = 1, din = 8'hA5, ser_ready = 1 -> ser_data sequence 1,0,1,0,0,1,0,1 over s = 0..7; ser_first on s = 0, ser_last on s = 7; frame_done exactly 1 cycle later.
REQ-036 Order: LSB_FIRST = 0, din = 8'h81 -> s = 7..0; ser_data = 1,0,0,0,0,0,0,1.
REQ-037 Back-pressure: ser_ready = 0 for 3 cycles at s = 4 -> s, w and ser_valid hold for 3 cycles; total frame = 11 cycles; the bit sequence is unchanged.
REQ-038 Back-to-back: IDLE_GAP = 0, din_valid held with 8'h0F then 8'hF0 -> second load on the last bit of the first frame; 16 contiguous valid bits; 2 frame_done pulses 8 cycles apart.
REQ-039 Gap: IDLE_GAP = 3 -> din_ready = 0 for 3 cycles after the frame, then 1; busy = 1 during the gap.
REQ-040 Reset mid-frame: rst pulsed at s = 5 -> next cycle state = IDLE, w = 8'h00, ser_valid = 0, no frame_done; a new load then starts at s = 0.
